// File: rtl/tlb_ctrl.sv
// tlb_ctrl: TLB access sequencer. It arbitrates fetch/memory lookups and CP0
// TLB ops (TLBP/TLBWI/TLBWR) onto a single TLB port, one access per cycle,
// and maintains the CP0 Random register.
// Optional macro TLB_CTRL_RR_EN: round-robin between fetch and memory
// lookups. When it is undefined, memory has fixed priority over fetch.
module tlb_ctrl #(
  parameter int NENTRY = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [18:0] if_vpn,
  output logic        if_done,
  output logic        if_hit,
  input  logic        mem_req,
  input  logic [18:0] mem_vpn,
  output logic        mem_done,
  output logic        mem_hit,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [18:0] op_vpn,
  input  logic [4:0]  cp0_index,
  input  logic [4:0]  cp0_wired,
  output logic        op_done,
  output logic        op_err,
  output logic [4:0]  probe_index,
  output logic        probe_fail,
  output logic [4:0]  random,
  output logic        tlb_ren,
  output logic [18:0] tlb_vaddr,
  output logic        tlb_wen,
  output logic [4:0]  tlb_windex,
  input  logic        tlb_hit,
  input  logic [4:0]  tlb_hit_index
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LKUP  = 3'd1;
  localparam logic [2:0] S_PROBE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] W_IF  = 2'd0;
  localparam logic [1:0] W_MEM = 2'd1;
  localparam logic [1:0] W_OP  = 2'd2;

  localparam logic [4:0] RMAX = 5'(NENTRY - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  who_q, who_d;
  logic [1:0]  opc_q, opc_d;
  logic [18:0] vpn_q, vpn_d;
  logic [4:0]  windex_q, windex_d;
  logic        hit_q, hit_d;
  logic [4:0]  pidx_q, pidx_d;
  logic        pfail_q, pfail_d;
  logic [4:0]  rand_q, rand_d;
  logic        gnt_mem, gnt_if;

`ifdef TLB_CTRL_RR_EN
  // rr_q=1: memory stage is favoured on the next simultaneous request
  logic rr_q, rr_d;

  // Lookup grant: the requester not granted last wins a tie
  always_comb begin
    gnt_mem = mem_req && (!if_req || rr_q);
    gnt_if  = if_req && !gnt_mem;
    rr_d    = rr_q;
    if (state_q == S_IDLE && !op_valid && (gnt_mem || gnt_if))
      rr_d = gnt_if;
  end

  // Round-robin pointer register, reset to favour memory
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_q <= 1'b1;
    else         rr_q <= rr_d;
  end
`else
  // Lookup grant: fixed priority, memory over fetch
  always_comb begin
    gnt_mem = mem_req;
    gnt_if  = if_req && !mem_req;
  end
`endif

  // FSM next state; ops win over lookups in IDLE
  always_comb begin
    state_d  = state_q;
    who_d    = who_q;
    opc_d    = opc_q;
    vpn_d    = vpn_q;
    windex_d = windex_q;
    hit_d    = hit_q;
    pidx_d   = pidx_q;
    pfail_d  = pfail_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          who_d = W_OP;
          opc_d = op_code;
          vpn_d = op_vpn;
          case (op_code)
            2'b00:   state_d = S_PROBE;
            2'b01:   begin state_d = S_WRITE; windex_d = cp0_index; end
            2'b10:   begin state_d = S_WRITE; windex_d = rand_q;    end
            default: state_d = S_DONE;   // reserved: flag error, no access
          endcase
        end else if (gnt_mem) begin
          who_d   = W_MEM;
          vpn_d   = mem_vpn;
          state_d = S_LKUP;
        end else if (gnt_if) begin
          who_d   = W_IF;
          vpn_d   = if_vpn;
          state_d = S_LKUP;
        end
      end
      S_LKUP: begin
        hit_d   = tlb_hit;
        state_d = S_DONE;
      end
      S_PROBE: begin
        if (tlb_hit) begin
          pidx_d  = tlb_hit_index;
          pfail_d = 1'b0;
        end else begin
          pfail_d = 1'b1;          // Index.P set, index left as it was
        end
        state_d = S_DONE;
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;   // S_DONE and any illegal encoding
    endcase
  end

  // Random: free-running down-counter over [wired, NENTRY-1], reloaded
  // after a completed indexed/random write
  always_comb begin
    if (state_q == S_DONE && who_q == W_OP && (opc_q[1] ^ opc_q[0]))
      rand_d = RMAX;
    else if (cp0_wired >= RMAX)
      rand_d = RMAX;
    else if (rand_q <= cp0_wired)
      rand_d = RMAX;
    else
      rand_d = rand_q - 5'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      who_q    <= W_IF;
      opc_q    <= 2'b00;
      vpn_q    <= '0;
      windex_q <= '0;
      hit_q    <= 1'b0;
      pidx_q   <= '0;
      pfail_q  <= 1'b0;
      rand_q   <= RMAX;
    end else begin
      state_q  <= state_d;
      who_q    <= who_d;
      opc_q    <= opc_d;
      vpn_q    <= vpn_d;
      windex_q <= windex_d;
      hit_q    <= hit_d;
      pidx_q   <= pidx_d;
      pfail_q  <= pfail_d;
      rand_q   <= rand_d;
    end
  end

  assign if_done     = (state_q == S_DONE) && (who_q == W_IF);
  assign mem_done    = (state_q == S_DONE) && (who_q == W_MEM);
  assign op_done     = (state_q == S_DONE) && (who_q == W_OP);
  assign if_hit      = if_done && hit_q;
  assign mem_hit     = mem_done && hit_q;
  assign op_err      = op_done && (opc_q == 2'b11);
  assign probe_index = pidx_q;
  assign probe_fail  = pfail_q;
  assign random      = rand_q;
  assign tlb_ren     = (state_q == S_LKUP) || (state_q == S_PROBE);
  assign tlb_wen     = (state_q == S_WRITE);
  assign tlb_vaddr   = vpn_q;
  assign tlb_windex  = windex_q;

endmodule
